// File: rtl/mon_reg_pkg.sv
// rtl/mon_reg_pkg.sv - shared widths and register addresses for the monitor register bank
package mon_reg_pkg;

    localparam int MON_DATA_W = 32;
    localparam int MON_ADDR_W = 8;

    localparam logic [MON_ADDR_W-1:0] MON_ADDR_CMD    = 8'h00;
    localparam logic [MON_ADDR_W-1:0] MON_ADDR_STATUS = 8'h01;
    localparam logic [MON_ADDR_W-1:0] MON_ADDR_CTRL   = 8'h02;
    localparam logic [MON_ADDR_W-1:0] MON_ADDR_COUNT  = 8'h03;

endpackage

// File: rtl/mon_pulse_chan.sv
// rtl/mon_pulse_chan.sv - one retriggerable active-low command pulse line
module mon_pulse_chan #(
    parameter int PULSE_W   = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic bclk,
    input  logic rst,
    input  logic trig,
    output logic pulse_b,
    output logic active
);

    generate
        if (PULSE_LEN < 1 || PULSE_LEN > (1 << PULSE_W) - 1) begin : g_bad_len
            $error("mon_pulse_chan: PULSE_LEN out of range for PULSE_W");
        end
    endgenerate

    logic [PULSE_W-1:0] cnt;
    logic [PULSE_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (trig) begin
            cnt_next = PULSE_W'(PULSE_LEN);
        end else if (cnt != '0) begin
            cnt_next = cnt - PULSE_W'(1);
        end
    end

    // active looks one edge ahead so the parent can register busy in step with pulse_b
    assign active = (cnt_next != '0);

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pulse_b <= 1'b1;
        end else begin
            cnt     <= cnt_next;
            pulse_b <= (cnt_next == '0);
        end
    end

endmodule

// File: rtl/mon_reg32cmd_pulse.sv
// rtl/mon_reg32cmd_pulse.sv - command register firing per-bit pulses with serial mask readback
module mon_reg32cmd_pulse
    import mon_reg_pkg::*;
#(
    parameter logic [MON_ADDR_W-1:0] REG_ADDR = MON_ADDR_CMD,
    parameter int N_FLAGS   = 6,
    parameter int PULSE_W   = 4,
    parameter int PULSE_LEN = 1
) (
    input  logic                  bclk,
    input  logic                  rst,
    input  logic [MON_DATA_W-1:0] dataIn,
    input  logic [MON_ADDR_W-1:0] addrIn,
    input  logic                  latchIn,
    input  logic                  readIn,
    output logic [N_FLAGS-1:0]    flags_rstb,
    output logic                  busy,
    output logic                  shiftOut
);

    generate
        if (N_FLAGS < 1 || N_FLAGS > MON_DATA_W) begin : g_bad_flags
            $error("mon_reg32cmd_pulse: N_FLAGS out of range");
        end
    endgenerate

    logic                  write_hit;
    logic                  read_hit;
    logic [N_FLAGS-1:0]    active;
    logic [MON_DATA_W-1:0] snap;
    logic [MON_DATA_W-1:0] sreg;
    logic                  unused_data;

    assign write_hit   = latchIn && (addrIn == REG_ADDR);
    assign read_hit    = readIn && (addrIn == REG_ADDR);
    assign unused_data = ^dataIn;

    genvar gi;
    generate
        for (gi = 0; gi < N_FLAGS; gi++) begin : g_chan
            mon_pulse_chan #(
                .PULSE_W   (PULSE_W),
                .PULSE_LEN (PULSE_LEN)
            ) u_chan (
                .bclk    (bclk),
                .rst     (rst),
                .trig    (write_hit && dataIn[gi]),
                .pulse_b (flags_rstb[gi]),
                .active  (active[gi])
            );
        end
    endgenerate

    // snapshot comes from the registered lines, so a same-cycle write is not yet visible
    always_comb begin
        snap = '0;
        for (int i = 0; i < N_FLAGS; i++) begin
            snap[i] = ~flags_rstb[i];
        end
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            sreg <= '0;
        end else begin
            busy <= |active;
            if (read_hit) begin
                sreg <= snap;
            end else begin
                sreg <= {sreg[MON_DATA_W-2:0], 1'b0};
            end
        end
    end

    assign shiftOut = sreg[MON_DATA_W-1];

endmodule

// File: tb/tb_mon_reg32cmd_pulse.sv
// tb/tb_mon_reg32cmd_pulse.sv - self-checking bench for mon_reg32cmd_pulse at three pulse lengths
module tb_mon_reg32cmd_pulse;
    import mon_reg_pkg::*;

    localparam int NF = 6;
    localparam logic [7:0] RA = MON_ADDR_CMD;
    localparam int NEVER = -1000;

    logic        bclk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dataIn = '0;
    logic [7:0]  addrIn = '0;
    logic        latchIn = 1'b0;
    logic        readIn = 1'b0;
    logic [NF-1:0] flags [3];
    logic        busy_v [3];
    logic        so_v [3];

    int errors = 0;
    int checks = 0;
    int e = 0;
    int plen [3] = '{3, 4, 8};
    int last [3][NF];
    int rd_edge [3];
    logic [31:0] rd_mask [3];

    always #5 bclk = ~bclk;

    mon_reg32cmd_pulse #(.REG_ADDR(RA), .N_FLAGS(NF), .PULSE_W(4), .PULSE_LEN(3)) dut0 (
        .bclk(bclk), .rst(rst), .dataIn(dataIn), .addrIn(addrIn), .latchIn(latchIn),
        .readIn(readIn), .flags_rstb(flags[0]), .busy(busy_v[0]), .shiftOut(so_v[0]));
    mon_reg32cmd_pulse #(.REG_ADDR(RA), .N_FLAGS(NF), .PULSE_W(4), .PULSE_LEN(4)) dut1 (
        .bclk(bclk), .rst(rst), .dataIn(dataIn), .addrIn(addrIn), .latchIn(latchIn),
        .readIn(readIn), .flags_rstb(flags[1]), .busy(busy_v[1]), .shiftOut(so_v[1]));
    mon_reg32cmd_pulse #(.REG_ADDR(RA), .N_FLAGS(NF), .PULSE_W(4), .PULSE_LEN(8)) dut2 (
        .bclk(bclk), .rst(rst), .dataIn(dataIn), .addrIn(addrIn), .latchIn(latchIn),
        .readIn(readIn), .flags_rstb(flags[2]), .busy(busy_v[2]), .shiftOut(so_v[2]));

    // A line is low after edge t iff its latest trigger edge k satisfies k <= t < k+len.
    function automatic logic [NF-1:0] mmask(int d, int t);
        logic [NF-1:0] m;
        for (int i = 0; i < NF; i++) m[i] = (t >= last[d][i]) && (t < last[d][i] + plen[d]);
        return m;
    endfunction

    function automatic logic [NF-1:0] exp_flags(int d);
        return ~mmask(d, e);
    endfunction

    function automatic logic exp_busy(int d);
        return |mmask(d, e);
    endfunction

    function automatic logic exp_so(int d);
        int k;
        logic [31:0] m;
        k = e - rd_edge[d];
        m = rd_mask[d];
        if (k >= 0 && k < 32) return m[31-k];
        return 1'b0;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < NF; i++) last[d][i] = NEVER;
            rd_edge[d] = NEVER;
            rd_mask[d] = '0;
        end
    endfunction

    task automatic step(input logic l, input logic [7:0] a, input logic [31:0] dat, input logic r);
        latchIn = l; addrIn = a; dataIn = dat; readIn = r;
        @(posedge bclk);
        e++;
        for (int d = 0; d < 3; d++) begin
            if (r && a == RA) begin
                rd_edge[d] = e;
                rd_mask[d] = {26'b0, mmask(d, e - 1)};
            end
            if (l && a == RA)
                for (int i = 0; i < NF; i++) if (dat[i]) last[d][i] = e;
        end
        #1;
        latchIn = 1'b0; readIn = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge bclk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (flags[d] !== 6'h3F || busy_v[d] !== 1'b0 || so_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset dut=%0d flags=%b busy=%b so=%b required 111111/0/0", d, flags[d], busy_v[d], so_v[d]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic run_idle(input string name, input int n);
        for (int c = 0; c < n; c++) begin
            if (c > 0) step(1'b0, RA, 32'h0, 1'b0);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (flags[d] !== exp_flags(d) || busy_v[d] !== exp_busy(d) || so_v[d] !== exp_so(d)) begin
                    errors++;
                    $display("FAIL %s dut=%0d edge=%0d flags=%b busy=%b so=%b required %b/%b/%b", name, d, e,
                             flags[d], busy_v[d], so_v[d], exp_flags(d), exp_busy(d), exp_so(d));
                end
            end
        end
    endtask

    task automatic test_single_pulse();
        step(1'b1, RA, 32'h05, 1'b0);
        checks++;
        if (flags[0] !== 6'b111010) begin
            errors++;
            $display("FAIL single_first flags=%b required 111010", flags[0]);
        end
        run_idle("single_pulse", 12);
    endtask

    task automatic test_miss();
        step(1'b1, RA + 8'd1, 32'h3F, 1'b0);
        run_idle("miss_addr", 4);
        step(1'b0, RA, 32'h3F, 1'b0);
        run_idle("miss_latch", 4);
    endtask

    task automatic test_retrigger();
        step(1'b1, RA, 32'h01, 1'b0);
        step(1'b0, RA, 32'h0, 1'b0);
        step(1'b1, RA, 32'h01, 1'b0);
        run_idle("retrigger", 12);
    endtask

    task automatic test_read_stream();
        step(1'b1, RA, 32'h22, 1'b0);
        step(1'b0, RA, 32'h0, 1'b1);
        run_idle("read_stream", 40);
    endtask

    task automatic test_write_read_same();
        step(1'b1, RA, 32'h2D, 1'b1);
        run_idle("write_read_same", 40);
    endtask

    task automatic test_async_reset();
        step(1'b1, RA, 32'h3F, 1'b0);
        step(1'b0, RA, 32'h0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (flags[d] !== 6'h3F || busy_v[d] !== 1'b0 || so_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut=%0d flags=%b busy=%b so=%b required 111111/0/0", d, flags[d], busy_v[d], so_v[d]);
            end
        end
        model_reset();
        @(posedge bclk);
        #1;
        rst = 1'b0;
        step(1'b1, RA, 32'h09, 1'b0);
        run_idle("after_reset", 10);
    endtask

    task automatic test_random();
        logic l, r;
        logic [7:0] a;
        for (int c = 0; c < 400; c++) begin
            l = ($urandom % 3) == 0;
            r = ($urandom % 5) == 0;
            a = (($urandom % 4) == 0) ? RA + 8'd1 : RA;
            step(l, a, $urandom & $urandom, r);
            run_idle("random", 1);
        end
        run_idle("random_drain", 40);
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_miss();
        test_retrigger();
        test_read_stream();
        test_write_read_same();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mon_reg32cmd_pulse.md
# mon_reg32cmd_pulse

Parametrised command register for the monitor register bank. A write to `REG_ADDR` fires one active-low pulse per set data bit on up to 32 independent command lines, each lasting a programmable number of `bclk` cycles, with retrigger on re-write. A read strobe snapshots the active-pulse mask into a 32-bit register that streams out serially on `shiftOut`. It sits on the same `addrIn`/`dataIn`/`latchIn` bus as the other monitor registers and drives reset/strobe inputs of downstream blocks.

## Interface
- `REG_ADDR`, default 8'h00: bus address this register decodes.
- `N_FLAGS`, default 6: number of command lines, legal range 1..32.
- `PULSE_W`, default 4: per-line counter width.
- `PULSE_LEN`, default 1: pulse length in `bclk` cycles, legal range 1..2^PULSE_W-1. An illegal value stops elaboration.
- `bclk`  in  1: the single clock. All logic is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `dataIn`  in  32: write data. Bit i commands line i; bits ≥ `N_FLAGS` are ignored.
- `addrIn`  in  8: bus address.
- `latchIn`  in  1: write strobe, sampled on the rising edge of `bclk`.
- `readIn`  in  1: read strobe, sampled on the rising edge of `bclk`.
- `flags_rstb`  out  N_FLAGS: active-low command pulses, registered.
- `busy`  out  1: OR of all active lines, registered.
- `shiftOut`  out  1: serial readback, MSB first.

## Operation
- Write hit: `latchIn`=1 and `addrIn`=`REG_ADDR`. A write with a different address does nothing.
- On a write hit, every line i < `N_FLAGS` with `dataIn[i]`=1 loads its counter with `PULSE_LEN`.
- Each line's counter decrements by 1 per cycle while it is non-zero and never goes below 0.
- `flags_rstb[i]` = 0 exactly while counter i ≠ 0. It is a registered output, so there are no glitches.
- Retrigger: a write hit on a line that is already active reloads its counter to `PULSE_LEN`. The pulse is extended and stays continuously low; it is never split.
- Lines with `dataIn[i]`=0 in a write hit are unaffected. There is no early abort.
- Read hit: `readIn`=1 and `addrIn`=`REG_ADDR`. It loads the 32-bit shift register with the active mask zero-extended to 32 bits: bit i = (counter i ≠ 0).
- `shiftOut` = `sreg[31]`. On every cycle without a read hit, `sreg` shifts left with 0 filled in. After 32 shifts it is all zeros, and `shiftOut` stays 0.
- A read hit during an ongoing shift restarts the stream with a fresh snapshot.
- A write hit and a read hit in the same cycle: the snapshot shows the pre-write mask. The write still takes effect.
- Reset state (asserted asynchronously, held while `rst`=1):
  - all counters 0;
  - `flags_rstb` all 1;
  - `busy` 0;
  - `sreg` 0, so `shiftOut` 0.
- Reset mid-pulse: the line goes high immediately, with no pulse completion. The first write after `rst` falls is honoured normally.

## Timing
- Write hit sampled at edge k: the affected `flags_rstb` bits go low after edge k and stay low for `PULSE_LEN` cycles. They return high after edge k+`PULSE_LEN`.
- `busy` follows the same timing as the OR of the lines.
- Retrigger at edge m while active: the line returns high after edge m+`PULSE_LEN`.
- Read hit at edge k: `shiftOut` shows bit 31 after edge k and bit 31-j after edge k+j, for j = 0..31.
- The block has no back-pressure and no handshake. Strobes may arrive on every cycle.

## Structure
- Shared package `mon_reg_pkg` holds:
  - `MON_DATA_W`=32 and `MON_ADDR_W`=8;
  - the monitor register address constants, so `REG_ADDR` is set from a named constant.
- Sub-module `mon_pulse_chan`, one instance per line via generate:
  - ports `bclk`, `rst`, `trig`, `pulse_b`, `active`;
  - parameters `PULSE_W`, `PULSE_LEN`;
  - contains the down-counter and the registered output.
- The top level holds the address decode, the `busy` OR register and the shift register.

## Test plan
- Reset release, then N_FLAGS=6, PULSE_LEN=3, write `dataIn`=32'h05 to `REG_ADDR` -> `flags_rstb`=6'b111010 for exactly 3 cycles, then 6'b111111. `busy` is high for the same 3 cycles.
- Same write with `addrIn`=`REG_ADDR`+1, and also with `latchIn`=0 -> `flags_rstb` stays all ones and `busy` stays 0.
- PULSE_LEN=4: write 32'h01, then write 32'h01 again 2 cycles later -> bit 0 is continuously low for 6 cycles.
- Write 32'h3F then `rst` pulsed 1 cycle later -> all lines high asynchronously, before the next edge. `busy`=0.
- Write 32'h22 (PULSE_LEN=8), read hit 1 cycle later -> `shiftOut` gives 26 zeros, then 1,0,0,0,1,0, then 0 forever.
- Write and read hit in the same cycle with all lines idle -> the stream is all zeros, while lines still pulse as written.
